mem_responder: RTL and testbench

- Memory-side responder for the processor memory bus; the other end of the processor's MemAddr/MemRd/MemWr/MemEnable/MemRdy initiator interface.
- Holds a synchronous byte-addressable RAM.
- Serves one word (32-bit) or byte read/write per request, after a programmable number of wait states.
- Signals completion with a one-cycle MemRdy pulse.
- Sits beside the Processor in the lab top level and replaces the behavioural memory model.

---
 rtl/mem_responder.sv | 89 ++++++++
 tb/tb_mem_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder that serves word/byte reads and writes after WAIT_CYCLES wait states.
// Ports: Clk/Reset (async, active-high); MemAddr byte address; toMemData write data (bytes use [7:0]);
// fromMemData read data, held until the next completed read; MemLength 1=word 0=byte;
// MemRd/MemWr/MemEnable request; MemRdy one-cycle completion pulse.
// Optional: define MEM_BOUNDS_CHECK_EN to discard out-of-range writes and return DEADBEEF on out-of-range reads
// (default: the word index wraps modulo DEPTH_WORDS).
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] MemAddr,
  input  logic [31:0] toMemData,
  output logic [31:0] fromMemData,
  input  logic        MemLength,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        MemEnable,
  output logic        MemRdy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, READY, RELEASE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic len, wr;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic oob, do_access;
  logic [31:0] word, rd_val, wbus;
  logic [3:0] be;
  assign idx = addr[AW+1:2];
  assign lane = addr[1:0];
`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = {1'b0, addr[23:2]} >= 23'(DEPTH_WORDS);
`else
  logic unused_hi;
  assign unused_hi = ^addr;
  assign oob = 1'b0;
`endif
  // A dropped MemEnable wins over completion so an abandoned request never touches the RAM.
  assign do_access = state == BUSY && MemEnable && cnt == 4'd0;
  assign word = mem[idx];
  assign rd_val = oob ? (len ? 32'hDEADBEEF : 32'h0000_00EF) : len ? word : {24'h0, word[8*lane +: 8]};
  assign be = (oob || !wr) ? 4'h0 : len ? 4'hF : 4'b0001 << lane;
  assign wbus = len ? wdata : {4{wdata[7:0]}};
  // RAM is deliberately outside the reset domain so its contents survive Reset.
  always_ff @(posedge Clk)
    for (int i = 0; i < 4; i++)
      if (do_access && be[i]) mem[idx][8*i +: 8] <= wbus[8*i +: 8];
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      MemRdy <= 1'b0;
      fromMemData <= 32'h0;
      cnt <= 4'd0;
      addr <= 24'h0;
      wdata <= 32'h0;
      len <= 1'b0;
      wr <= 1'b0;
    end else begin
      MemRdy <= 1'b0;
      case (state)
        IDLE:
          if (MemEnable && (MemRd ^ MemWr)) begin
            addr <= MemAddr;
            wdata <= toMemData;
            len <= MemLength;
            wr <= MemWr;
            cnt <= 4'(WAIT_CYCLES);
            state <= BUSY;
          end
        BUSY:
          if (!MemEnable) state <= IDLE;
          else if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            MemRdy <= 1'b1;
            if (!wr) fromMemData <= rd_val;
            state <= READY;
          end
        READY: state <= MemEnable ? RELEASE : IDLE;
        RELEASE: state <= MemEnable ? RELEASE : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int DEPTH = 1024;
  localparam int W = 2;
  logic Clk = 0, Reset = 1;
  logic [23:0] MemAddr = 0;
  logic [31:0] toMemData = 0, fromMemData;
  logic MemLength = 0, MemRd = 0, MemWr = 0, MemEnable = 0, MemRdy;
  int checks = 0, errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd = 0;
  always #5 Clk = ~Clk;
  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset), .MemAddr(MemAddr), .toMemData(toMemData), .fromMemData(fromMemData),
    .MemLength(MemLength), .MemRd(MemRd), .MemWr(MemWr), .MemEnable(MemEnable), .MemRdy(MemRdy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic oob(input logic [23:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return int'(a >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] model_read(input logic [23:0] a, input logic len);
    logic [31:0] w;
    if (oob(a)) return len ? 32'hDEADBEEF : 32'h0000_00EF;
    w = ref_mem[int'(a >> 2) % DEPTH];
    return len ? w : (w >> (8 * a[1:0])) & 32'hFF;
  endfunction
  task automatic model_write(input logic [23:0] a, input logic len, input logic [31:0] d);
    int i;
    logic [31:0] m;
    if (oob(a)) return;
    i = int'(a >> 2) % DEPTH;
    m = 32'hFF << (8 * a[1:0]);
    ref_mem[i] = len ? d : (ref_mem[i] & ~m) | ((d & 32'hFF) << (8 * a[1:0]));
  endtask
  task automatic req(input logic rd, input logic len, input logic [23:0] a, input logic [31:0] d, input int hold);
    int n = 0, pulses = 0;
    logic got = 0;
    logic [31:0] exp;
    @(negedge Clk);
    MemAddr = a; toMemData = d; MemLength = len; MemRd = rd; MemWr = !rd; MemEnable = 1;
    while (n < 20 && !got) begin
      @(negedge Clk);
      n++;
      got = MemRdy;
    end
    chk("latency", 32'(n), 32'(W + 2));
    if (got) begin
      if (rd) begin
        exp = model_read(a, len);
        chk("rdata", fromMemData, exp);
        last_rd = exp;
      end else begin
        chk("wr_keeps_rdata", fromMemData, last_rd);
        model_write(a, len, d);
      end
    end
    repeat (1 + hold) begin
      @(negedge Clk);
      pulses += int'(MemRdy);
    end
    chk("pulse_width", 32'(pulses), 0);
    MemEnable = 0; MemRd = 0; MemWr = 0;
    @(negedge Clk);
  endtask
  initial begin
    int pulses;
    logic [23:0] a;
    #1;
    chk("reset_rdy", {31'h0, MemRdy}, 0);
    chk("reset_data", fromMemData, 0);
    repeat (2) @(negedge Clk);
    Reset = 0;
    for (int i = 0; i < 16; i++) req(0, 1, 24'(4 * i), $urandom, 0);
    req(0, 1, 24'h10, 32'h12345678, 0);
    req(1, 1, 24'h10, 0, 0);
    chk("tp_word", fromMemData, 32'h12345678);
    req(0, 0, 24'h11, 32'h000000AB, 0);
    req(1, 1, 24'h10, 0, 0);
    chk("tp_byte_merge", fromMemData, 32'h1234AB78);
    req(1, 0, 24'h13, 0, 0);
    chk("tp_byte_read", fromMemData, 32'h00000012);
    @(negedge Clk);
    MemAddr = 24'h10; toMemData = 32'h0; MemLength = 1; MemRd = 1; MemWr = 1; MemEnable = 1;
    pulses = 0;
    repeat (10) begin
      @(negedge Clk);
      pulses += int'(MemRdy);
    end
    chk("illegal_no_rdy", 32'(pulses), 0);
    MemEnable = 0; MemRd = 0; MemWr = 0;
    @(negedge Clk);
    req(1, 1, 24'h10, 0, 0);
    req(1, 1, 24'h24, 0, 8);
    req(1, 0, 24'h26, 0, 0);
    @(negedge Clk);
    MemAddr = 24'h20; toMemData = 32'hFFFFFFFF; MemLength = 1; MemRd = 0; MemWr = 1; MemEnable = 1;
    @(posedge Clk);
    @(posedge Clk);
    #2 Reset = 1;
    #1;
    chk("midreset_rdy", {31'h0, MemRdy}, 0);
    chk("midreset_data", fromMemData, 0);
    @(negedge Clk);
    MemEnable = 0; MemWr = 0;
    chk("midreset_rdy2", {31'h0, MemRdy}, 0);
    @(negedge Clk);
    Reset = 0;
    last_rd = 0;
    req(1, 1, 24'h20, 0, 0);
    req(0, 1, 24'h1000, 32'hCAFEF00D, 0);
    req(1, 1, 24'h1000, 0, 0);
    req(1, 1, 24'h0, 0, 0);
    req(1, 0, 24'h1003, 0, 0);
    for (int i = 0; i < 200; i++) begin
      a = 24'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a += 24'(32'h1000 * $urandom_range(1, 3));
      req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
